// File: rtl/hazard_pkg.sv
// Shared pipeline constants for the Tuse/Tnew hazard scheme.
//   TUSE_NONE  : Tuse code meaning the operand is never read
//   FWD_*      : forward-mux select encoding used by every stage
//   sat_dec    : Tnew countdown that stops at zero instead of wrapping
package hazard_pkg;

  localparam int TNEW_W = 2;
  localparam int AW     = 5;

  localparam logic [1:0] TUSE_NONE = 2'b11;

  localparam logic [1:0] FWD_NONE = 2'b00;  // register file / pipe value
  localparam logic [1:0] FWD_E    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_W    = 2'b11;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One tracking stage: a bundle of register addresses plus the producer's
// remaining Tnew. Each load counts Tnew down by one cycle (saturating).
//   clk, reset : pipeline clock, async active-low clear
//   bubble     : load an empty stage (all fields zero) instead of a_in
//   a_in       : addresses from the younger stage
//   tnew_in    : younger stage's Tnew (decremented on load)
//   a_q, tnew_q: registered stage contents
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter int N_ADDR = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bubble,
  input  logic [N_ADDR-1:0][AW-1:0]   a_in,
  input  logic [TNEW_W-1:0]           tnew_in,
  output logic [N_ADDR-1:0][AW-1:0]   a_q,
  output logic [TNEW_W-1:0]           tnew_q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      tnew_q <= '0;
    end else if (bubble) begin
      a_q    <= '0;
      tnew_q <= '0;
    end else begin
      a_q    <= a_in;
      tnew_q <= sat_dec(tnew_in);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for a 5-stage pipeline using Tuse/Tnew.
// Tracks destination addresses and remaining Tnew of instructions in E, M, W
// and compares them against the operands of the instruction in D.
//   clk, reset          : pipeline clock, async active-low reset
//   TuseRs/TuseRt       : D-stage cycles until rs/rt needed (TUSE_NONE = unused)
//   TnewD               : D-stage cycles until result produced
//   A1D/A2D/A3D         : D-stage rs, rt, destination (0 = no write)
//   stall               : freeze F/D, bubble into E
//   FwdRsD/FwdRtD       : D-stage operand source select
//   FwdRsE/FwdRtE       : E-stage operand source select
//   FwdRtM              : M-stage store-data source select
module hazard_ctrl #(
  parameter logic [1:0] TUSE_NONE = hazard_pkg::TUSE_NONE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] TuseRs,
  input  logic [1:0] TuseRt,
  input  logic [1:0] TnewD,
  input  logic [4:0] A1D,
  input  logic [4:0] A2D,
  input  logic [4:0] A3D,
  output logic       stall,
  output logic [1:0] FwdRsD,
  output logic [1:0] FwdRtD,
  output logic [1:0] FwdRsE,
  output logic [1:0] FwdRtE,
  output logic [1:0] FwdRtM
);
  import hazard_pkg::*;

  logic [2:0][AW-1:0] e_a;   // [0]=A1E [1]=A2E [2]=A3E
  logic [1:0][AW-1:0] m_a;   // [0]=A2M [1]=A3M
  logic [TNEW_W-1:0]  tnew_e, tnew_m;
  logic [AW-1:0]      a3w;
  logic               stall_rs, stall_rt;

  hazard_stage_reg #(.N_ADDR(3)) u_e (
    .clk     (clk),
    .reset   (reset),
    .bubble  (stall),
    .a_in    ({A3D, A2D, A1D}),
    .tnew_in (TnewD),
    .a_q     (e_a),
    .tnew_q  (tnew_e)
  );

  // M keeps advancing during a stall; only E takes the bubble.
  hazard_stage_reg #(.N_ADDR(2)) u_m (
    .clk     (clk),
    .reset   (reset),
    .bubble  (1'b0),
    .a_in    ({e_a[2], e_a[1]}),
    .tnew_in (tnew_e),
    .a_q     (m_a),
    .tnew_q  (tnew_m)
  );

  // W result is always ready, so only the address is tracked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) a3w <= '0;
    else        a3w <= m_a[1];
  end

  function automatic logic need_stall(
    input logic [1:0]        tuse,
    input logic [AW-1:0]     a,
    input logic [AW-1:0]     a3e,
    input logic [AW-1:0]     a3m,
    input logic [TNEW_W-1:0] te,
    input logic [TNEW_W-1:0] tm
  );
    return (tuse != TUSE_NONE) && (a != '0) &&
           (((a == a3e) && (te > tuse)) || ((a == a3m) && (tm > tuse)));
  endfunction

  // Youngest match wins; if it is not ready yet, older stages hold stale
  // data for this register, so nothing is forwarded and stall covers it.
  function automatic logic [1:0] fwd_d(
    input logic [AW-1:0]     a,
    input logic [AW-1:0]     a3e,
    input logic [TNEW_W-1:0] te,
    input logic [AW-1:0]     a3m,
    input logic [TNEW_W-1:0] tm,
    input logic [AW-1:0]     a3w_i
  );
    if (a == '0)        return FWD_NONE;
    else if (a == a3e)  return (te == '0) ? FWD_E : FWD_NONE;
    else if (a == a3m)  return (tm == '0) ? FWD_M : FWD_NONE;
    else if (a == a3w_i) return FWD_W;
    else                return FWD_NONE;
  endfunction

  function automatic logic [1:0] fwd_e(
    input logic [AW-1:0]     a,
    input logic [AW-1:0]     a3m,
    input logic [TNEW_W-1:0] tm,
    input logic [AW-1:0]     a3w_i
  );
    if (a == '0)         return FWD_NONE;
    else if (a == a3m)   return (tm == '0) ? FWD_M : FWD_NONE;
    else if (a == a3w_i) return FWD_W;
    else                 return FWD_NONE;
  endfunction

  always_comb begin
    stall_rs = need_stall(TuseRs, A1D, e_a[2], m_a[1], tnew_e, tnew_m);
    stall_rt = need_stall(TuseRt, A2D, e_a[2], m_a[1], tnew_e, tnew_m);
    stall    = stall_rs | stall_rt;
    FwdRsD   = fwd_d(A1D, e_a[2], tnew_e, m_a[1], tnew_m, a3w);
    FwdRtD   = fwd_d(A2D, e_a[2], tnew_e, m_a[1], tnew_m, a3w);
    FwdRsE   = fwd_e(e_a[0], m_a[1], tnew_m, a3w);
    FwdRtE   = fwd_e(e_a[1], m_a[1], tnew_m, a3w);
    FwdRtM   = ((m_a[0] != '0) && (m_a[0] == a3w)) ? FWD_W : FWD_NONE;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each applied D-stage vector pushes its
// hand-derived expected {stall,FwdRsD,FwdRtD,FwdRsE,FwdRtE,FwdRtM}, which is
// popped and compared at the following falling edge.
module tb_hazard_ctrl;

  localparam logic [1:0] NU = 2'b11;  // Tuse: operand unused

  typedef logic [10:0] vec_t;
  typedef struct packed {
    logic [1:0] trs, trt, tn;
    logic [4:0] a1, a2, a3;
    vec_t       exp;
  } row_t;

  logic       clk, reset;
  logic [1:0] TuseRs, TuseRt, TnewD;
  logic [4:0] A1D, A2D, A3D;
  logic       stall;
  logic [1:0] FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM;
  vec_t       obs;

  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .TuseRs(TuseRs), .TuseRt(TuseRt), .TnewD(TnewD),
    .A1D(A1D), .A2D(A2D), .A3D(A3D),
    .stall(stall), .FwdRsD(FwdRsD), .FwdRtD(FwdRtD),
    .FwdRsE(FwdRsE), .FwdRtE(FwdRtE), .FwdRtM(FwdRtM)
  );

  assign obs = {stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t ev(input logic s, input logic [1:0] rsd, rtd, rse, rte, rtm);
    return {s, rsd, rtd, rse, rte, rtm};
  endfunction

  function automatic row_t mk(input logic [1:0] trs, trt, tn,
                              input logic [4:0] a1, a2, a3, input vec_t e);
    row_t r;
    r = {trs, trt, tn, a1, a2, a3, e};
    return r;
  endfunction

  task automatic drive(input row_t r);
    TuseRs = r.trs; TuseRt = r.trt; TnewD = r.tn;
    A1D = r.a1; A2D = r.a2; A3D = r.a3;
  endtask

  // Present one D-stage vector for one cycle and queue its expectation.
  task automatic apply(input row_t r);
    @(posedge clk); #1;
    drive(r);
    sb.push_back(r.exp);
    @(negedge clk);
  endtask

  // Three idle cycles so E, M and W all hold empty stages.
  task automatic flush();
    repeat (3) begin
      @(posedge clk); #1;
      drive(mk(NU, NU, 2'd0, 5'd0, 5'd0, 5'd0, '0));
    end
  endtask

  task automatic test_reset();
    vec_t got, exp;
    reset = 1'b0;
    drive(mk(2'd0, NU, 2'd3, 5'd5, 5'd0, 5'd5, '0));
    @(posedge clk); #1;
    sb.push_back(ev(0, 0, 0, 0, 0, 0));
    got = obs; exp = sb.pop_front(); n_vec++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_state got=%b want=%b", got, exp); end
    repeat (2) @(posedge clk);
    #1;
    drive(mk(2'd0, 2'd0, 2'd0, 5'd5, 5'd5, 5'd0, '0));
    sb.push_back(ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = obs; exp = sb.pop_front(); n_vec++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_held got=%b want=%b", got, exp); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    row_t t[4];
    vec_t got, exp;
    t[0] = mk(2'd1, NU,   2'd3, 5'd1, 5'd0, 5'd3, ev(0, 0, 0, 0, 0, 0)); // lw $3
    t[1] = mk(2'd1, 2'd1, 2'd2, 5'd3, 5'd6, 5'd7, ev(1, 0, 0, 0, 0, 0)); // addu reads $3
    t[2] = mk(2'd1, 2'd1, 2'd2, 5'd3, 5'd6, 5'd7, ev(0, 0, 0, 0, 0, 0)); // held addu
    t[3] = mk(NU,   NU,   2'd0, 5'd0, 5'd0, 5'd0, ev(0, 0, 0, 3, 0, 0)); // addu in E
    flush();
    foreach (t[i]) begin
      apply(t[i]);
      got = obs; exp = sb.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL load_use[%0d] got=%b want=%b", i, got, exp); end
    end
  endtask

  task automatic test_alu_branch();
    row_t t[4];
    vec_t got, exp;
    t[0] = mk(2'd1, 2'd1, 2'd2, 5'd8, 5'd9, 5'd5, ev(0, 0, 0, 0, 0, 0)); // addu $5
    t[1] = mk(2'd0, 2'd0, 2'd0, 5'd5, 5'd0, 5'd0, ev(1, 0, 0, 0, 0, 0)); // beq $5
    t[2] = mk(2'd0, 2'd0, 2'd0, 5'd5, 5'd0, 5'd0, ev(0, 2, 0, 0, 0, 0)); // held, fwd M
    t[3] = mk(NU,   NU,   2'd0, 5'd0, 5'd0, 5'd0, ev(0, 0, 0, 3, 0, 0));
    flush();
    foreach (t[i]) begin
      apply(t[i]);
      got = obs; exp = sb.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL alu_branch[%0d] got=%b want=%b", i, got, exp); end
    end
  endtask

  task automatic test_dual_match();
    row_t t[4];
    vec_t got, exp;
    t[0] = mk(NU,   NU,   2'd1, 5'd0, 5'd0, 5'd4, ev(0, 0, 0, 0, 0, 0)); // writes $4
    t[1] = mk(NU,   NU,   2'd1, 5'd0, 5'd0, 5'd4, ev(0, 0, 0, 0, 0, 0)); // writes $4 again
    t[2] = mk(2'd0, 2'd0, 2'd0, 5'd4, 5'd4, 5'd0, ev(0, 1, 1, 0, 0, 0)); // E beats M
    t[3] = mk(NU,   NU,   2'd0, 5'd0, 5'd0, 5'd0, ev(0, 0, 0, 2, 2, 0)); // M beats W
    flush();
    foreach (t[i]) begin
      apply(t[i]);
      got = obs; exp = sb.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL dual_match[%0d] got=%b want=%b", i, got, exp); end
    end
  endtask

  task automatic test_zero_reg();
    row_t t[4];
    vec_t got, exp;
    t[0] = mk(NU,   NU,   2'd3, 5'd0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    t[1] = mk(2'd0, 2'd0, 2'd3, 5'd0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    t[2] = mk(2'd0, 2'd0, 2'd3, 5'd0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    t[3] = mk(NU,   NU,   2'd0, 5'd0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    flush();
    foreach (t[i]) begin
      apply(t[i]);
      got = obs; exp = sb.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL zero_reg[%0d] got=%b want=%b", i, got, exp); end
    end
  endtask

  task automatic test_sw_data();
    row_t t[4];
    vec_t got, exp;
    t[0] = mk(2'd1, NU,   2'd3, 5'd29, 5'd0, 5'd2, ev(0, 0, 0, 0, 0, 0)); // lw $2
    t[1] = mk(2'd1, 2'd2, 2'd0, 5'd29, 5'd2, 5'd0, ev(0, 0, 0, 0, 0, 0)); // sw $2
    t[2] = mk(NU,   NU,   2'd0, 5'd0,  5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0)); // M not ready
    t[3] = mk(NU,   NU,   2'd0, 5'd0,  5'd0, 5'd0, ev(0, 0, 0, 0, 0, 3)); // store data W
    flush();
    foreach (t[i]) begin
      apply(t[i]);
      got = obs; exp = sb.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL sw_data[%0d] got=%b want=%b", i, got, exp); end
    end
  endtask

  task automatic test_rt_stall();
    row_t t[4];
    vec_t got, exp;
    t[0] = mk(2'd1, NU,   2'd3, 5'd1, 5'd0, 5'd6, ev(0, 0, 0, 0, 0, 0));
    t[1] = mk(NU,   2'd1, 2'd2, 5'd6, 5'd6, 5'd8, ev(1, 0, 0, 0, 0, 0));
    t[2] = mk(NU,   2'd1, 2'd2, 5'd6, 5'd6, 5'd8, ev(0, 0, 0, 0, 0, 0));
    t[3] = mk(NU,   NU,   2'd0, 5'd0, 5'd0, 5'd0, ev(0, 0, 0, 3, 3, 0));
    flush();
    foreach (t[i]) begin
      apply(t[i]);
      got = obs; exp = sb.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL rt_stall[%0d] got=%b want=%b", i, got, exp); end
    end
  endtask

  // Tnew=0 must stay 0 through E and M rather than wrapping to 3.
  task automatic test_saturate();
    row_t t[4];
    vec_t got, exp;
    t[0] = mk(NU,   NU, 2'd0, 5'd0, 5'd0, 5'd7, ev(0, 0, 0, 0, 0, 0));
    t[1] = mk(2'd0, NU, 2'd0, 5'd7, 5'd0, 5'd0, ev(0, 1, 0, 0, 0, 0));
    t[2] = mk(2'd0, NU, 2'd0, 5'd7, 5'd0, 5'd0, ev(0, 2, 0, 2, 0, 0));
    t[3] = mk(2'd0, NU, 2'd0, 5'd7, 5'd0, 5'd0, ev(0, 3, 0, 3, 0, 0));
    flush();
    foreach (t[i]) begin
      apply(t[i]);
      got = obs; exp = sb.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL saturate[%0d] got=%b want=%b", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t t[3];
    vec_t got, exp;
    t[0] = mk(NU,   NU,   2'd1, 5'd0, 5'd0,  5'd10, ev(0, 0, 0, 0, 0, 0)); // writes $10
    t[1] = mk(2'd1, NU,   2'd3, 5'd1, 5'd0,  5'd3,  ev(0, 0, 0, 0, 0, 0)); // lw $3
    t[2] = mk(2'd0, 2'd0, 2'd0, 5'd3, 5'd10, 5'd0,  ev(1, 0, 2, 0, 0, 0)); // stalled reader
    flush();
    foreach (t[i]) begin
      apply(t[i]);
      got = obs; exp = sb.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL mid_stall[%0d] got=%b want=%b", i, got, exp); end
    end
    #1 reset = 1'b0;
    sb.push_back(ev(0, 0, 0, 0, 0, 0));
    #1;
    got = obs; exp = sb.pop_front(); n_vec++;
    if (got !== exp) begin n_bad++; $display("FAIL async_reset got=%b want=%b", got, exp); end
    @(posedge clk); #1;
    reset = 1'b1;
    sb.push_back(ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = obs; exp = sb.pop_front(); n_vec++;
    if (got !== exp) begin n_bad++; $display("FAIL after_release got=%b want=%b", got, exp); end
  endtask

  initial begin
    reset = 1'b0;
    drive(mk(NU, NU, 2'd0, 5'd0, 5'd0, 5'd0, '0));
    test_reset();
    test_load_use();
    test_alu_branch();
    test_dual_match();
    test_zero_reg();
    test_sw_data();
    test_rt_stall();
    test_saturate();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: TUSE_NONE, 2'b11; Tuse value meaning the operand is not read.
REQ-002 clk  input  1  single pipeline clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 TuseRs  input  2  D-stage cycles until rs is needed; TUSE_NONE means unused.
REQ-005 TuseRt  input  2  D-stage cycles until rt is needed; TUSE_NONE means unused.
REQ-006 TnewD  input  2  D-stage cycles until the result is produced.
REQ-007 A1D  input  5  D-stage rs address.
REQ-008 A2D  input  5  D-stage rt address.
REQ-009 A3D  input  5  D-stage destination address; 0 means no write.
REQ-010 stall  output  1  freeze F/D registers and insert a bubble into E.
REQ-011 FwdRsD  output  2  D-stage rs source select.
REQ-012 FwdRtD  output  2  D-stage rt source select.
REQ-013 FwdRsE  output  2  E-stage rs source select.
REQ-014 FwdRtE  output  2  E-stage rt source select.
REQ-015 FwdRtM  output  2  M-stage rt source select.

Function
REQ-016 Forward select encoding SHALL be: 00 register file/pipe, 01 E result, 10 M result, 11 W result.
REQ-017 Block SHALL keep per-stage tracking registers: E {A1E,A2E,A3E,TnewE}, M {A2M,A3M,TnewM}, W {A3W}.
REQ-018 When stall=0, each clock edge SHALL load: E from D inputs with TnewE=sat_dec(TnewD); M from E with TnewM=sat_dec(TnewE); W from M.
REQ-019 sat_dec(x) SHALL be x-1 for x>0 and 0 for x=0; no wrap-around.
REQ-020 When stall=1, E SHALL load a bubble (all fields 0) while M and W advance normally.
REQ-021 A register address of 0 SHALL never match any producer.
REQ-022 stall_rs SHALL be 1 when TuseRs!=TUSE_NONE, A1D!=0, and either (A1D==A3E and TnewE>TuseRs) or (A1D==A3M and TnewM>TuseRs).
REQ-023 stall_rt SHALL follow the REQ-022 rule using A2D and TuseRt.
REQ-024 stall SHALL be the combinational OR of stall_rs and stall_rt, valid in the same cycle the D inputs arrive.
REQ-025 FwdRsD/FwdRtD SHALL pick the youngest matching producer with Tnew==0 in priority E>M>W; otherwise 00.
REQ-026 FwdRsE/FwdRtE SHALL pick from M (TnewM==0), then W; E as a source is illegal.
REQ-027 FwdRtM SHALL be 11 when A2M==A3W and A2M!=0; otherwise 00.
REQ-028 If the youngest match has Tnew>0, an older ready stage SHALL NOT be selected; stall covers that case.
REQ-029 Forward outputs SHALL be combinational from current tracking registers and D inputs.

Reset
REQ-030 reset=0 SHALL asynchronously clear all tracking registers to 0, forcing stall=0 and all Fwd* outputs to 00.
REQ-031 Reset asserted mid-stall SHALL discard in-flight producers; the first cycle after release SHALL see an empty pipe.

Structure
REQ-032 TUSE_NONE, the FWD_NONE/E/M/W encodings and the sat_dec width SHALL live in the shared pipeline package used by the Tuse/Tnew decoder.
REQ-033 One sub-module, hazard_stage_reg (address plus Tnew register with bubble and saturating decrement), SHALL be instantiated for the E and M stages.
REQ-034 Target RTL size is 150-300 lines.

Verification
REQ-035 Load-use: lw $3 (TnewD=3, A3D=3), then addu reading $3 (TuseRs=1) -> stall=1 for exactly 1 cycle, then FwdRsE=11 when the consumer is in E.
REQ-036 ALU-to-branch: addu $5 (TnewD=2), then beq on $5 (TuseRs=0) -> stall 1 cycle, then FwdRsD=10.
REQ-037 Dual match: $4 written in both E (TnewE=0) and M (TnewM=0), reader in D -> FwdRsD=01.
REQ-038 $0 hazard: producer A3D=0, reader A1D=0 -> stall=0 and FwdRsD=00 across all stages.
REQ-039 sw data: lw $2, then sw using $2 as rt (TuseRt=2) -> no stall; FwdRtM=11 on the store's M cycle.
REQ-040 Async reset asserted during a lw stall -> stall and all Fwd* outputs drop to 0 immediately, with no clock edge required.
